slurm16_mem_arbiter: RTL

//  Shares the single-port 16-bit main RAM (mem0) between NPORTS requesters: CPU data port, CPU instruction fetch, DMA.

---
 rtl/slurm16_arb_pkg.sv | 24 ++
 rtl/slurm16_arb_pick.sv | 30 +++
 rtl/slurm16_mem_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/slurm16_arb_pkg.sv
// Shared types and width helpers for the slurm16 main-RAM arbiter.
// Round-robin IDLE arbitration is enabled by defining SLURM16_ARB_ROUND_ROBIN_EN.
package slurm16_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_NPORTS    = 3;
  localparam int DEF_ADDR_BITS = 16;
  localparam int DEF_BITS      = 16;
  localparam int DEF_BURST_MAX = 8;

  // A single-port build still needs a 1-bit index to stay legal.
  function automatic int port_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int burst_cnt_w(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/slurm16_arb_pick.sv
// Combinational one-hot picker: first set request found scanning upward
// (with wrap) from the start index.
module slurm16_arb_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(start) + off) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/slurm16_mem_arbiter.sv
// Single-port main RAM arbiter for slurm16: fixed-priority (or round-robin when
// SLURM16_ARB_ROUND_ROBIN_EN is defined) grant with burst lock, 2-cycle read return.
module slurm16_mem_arbiter
  import slurm16_arb_pkg::*;
#(
  parameter int NPORTS    = DEF_NPORTS,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int BITS      = DEF_BITS,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NPORTS-1:0]           req_valid,
  input  logic [NPORTS-1:0]           req_wr,
  input  logic [NPORTS-1:0]           req_lock,
  input  logic [NPORTS*ADDR_BITS-1:0] req_addr,
  input  logic [NPORTS*BITS-1:0]      req_wdata,
  output logic [NPORTS-1:0]           req_ready,
  output logic [NPORTS-1:0]           rsp_valid,
  output logic [BITS-1:0]             rsp_rdata,
  output logic                        mem_en,
  output logic                        mem_wr,
  output logic [ADDR_BITS-1:0]        mem_addr,
  output logic [BITS-1:0]             mem_wdata,
  input  logic [BITS-1:0]             mem_rdata
);

  localparam int PORT_IDX_W  = port_idx_w(NPORTS);
  localparam int BURST_CNT_W = burst_cnt_w(BURST_MAX);

  arb_state_e               state_q, state_d;
  logic [PORT_IDX_W-1:0]    owner_q, owner_d;
  logic [BURST_CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [BURST_CNT_W:0]     burst_next;

  logic [NPORTS-1:0]        pick_req, grant;
  logic [PORT_IDX_W-1:0]    win_idx, start_idx;
  logic                     pick_any, accept, owner_hold;

  logic [ADDR_BITS-1:0]     addr_arr [NPORTS];
  logic [BITS-1:0]          wdata_arr [NPORTS];

  logic                     mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
  logic [ADDR_BITS-1:0]     mem_addr_q, mem_addr_d;
  logic [BITS-1:0]          mem_wdata_q, mem_wdata_d;
  logic                     tag1_valid_q, tag1_valid_d, tag2_valid_q, tag2_valid_d;
  logic [PORT_IDX_W-1:0]    tag1_port_q, tag1_port_d, tag2_port_q, tag2_port_d;

  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_BITS +: ADDR_BITS];
      assign wdata_arr[gi] = req_wdata[gi*BITS +: BITS];
    end
  endgenerate

  // A locked owner that is still requesting masks every other port.
  assign owner_hold = (state_q == ARB_LOCKED) && req_valid[owner_q];
  assign pick_req   = owner_hold ? (req_valid & (NPORTS'(1) << owner_q)) : req_valid;

`ifdef SLURM16_ARB_ROUND_ROBIN_EN
  logic [PORT_IDX_W-1:0] last_winner_q, last_winner_d;

  assign last_winner_d = accept ? win_idx : last_winner_q;
  assign start_idx = (int'(last_winner_q) == NPORTS - 1) ? '0 : last_winner_q + 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) last_winner_q <= PORT_IDX_W'(NPORTS - 1);
    else     last_winner_q <= last_winner_d;
  end
`else
  assign start_idx = '0;
`endif

  slurm16_arb_pick #(
    .N  (NPORTS),
    .IW (PORT_IDX_W)
  ) u_pick (
    .req       (pick_req),
    .start     (start_idx),
    .grant     (grant),
    .grant_idx (win_idx),
    .any       (pick_any)
  );

  assign accept = pick_any && !RST;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    burst_next  = owner_hold ? ({1'b0, burst_cnt_q} + 1'b1) : (BURST_CNT_W+1)'(1);
    if (accept) begin
      if (req_lock[win_idx] && (int'(burst_next) < BURST_MAX)) begin
        state_d     = ARB_LOCKED;
        owner_d     = win_idx;
        burst_cnt_d = burst_next[BURST_CNT_W-1:0];
      end else begin
        state_d     = ARB_IDLE;
        burst_cnt_d = '0;
      end
    end else if ((state_q == ARB_LOCKED) && !owner_hold) begin
      state_d     = ARB_IDLE;
      burst_cnt_d = '0;
    end
  end

  // Output logic
  always_comb begin
    req_ready = RST ? '0 : grant;
    rsp_valid = '0;
    rsp_rdata = '0;
    if (tag2_valid_q) begin
      rsp_valid[tag2_port_q] = 1'b1;
      rsp_rdata              = mem_rdata;
    end
  end

  // RAM command stage and read-tag pipeline, aligned with the RAM's 1-cycle latency.
  always_comb begin
    mem_en_d     = accept;
    mem_wr_d     = accept && req_wr[win_idx];
    mem_addr_d   = accept ? addr_arr[win_idx]  : mem_addr_q;
    mem_wdata_d  = accept ? wdata_arr[win_idx] : mem_wdata_q;
    tag1_valid_d = accept && !req_wr[win_idx];
    tag1_port_d  = accept ? win_idx : tag1_port_q;
    tag2_valid_d = tag1_valid_q;
    tag2_port_d  = tag1_port_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_en_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      tag1_valid_q <= 1'b0;
      tag1_port_q  <= '0;
      tag2_valid_q <= 1'b0;
      tag2_port_q  <= '0;
    end else begin
      mem_en_q     <= mem_en_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      tag1_valid_q <= tag1_valid_d;
      tag1_port_q  <= tag1_port_d;
      tag2_valid_q <= tag2_valid_d;
      tag2_port_q  <= tag2_port_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
